// File: rtl/enc_pkg.sv
// Quadrature encoder shared definitions: Gray-code state encodings, direction polarity, default timing.
// Also used by encoder_mmio, so the count direction polarity is defined in one place.
package enc_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_10 = 2'b10,
    QS_11 = 2'b11,
    QS_01 = 2'b01
  } quad_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 4;

  // Successor of a {A,B} state in the forward (A leads B) sequence.
  function automatic logic [1:0] qs_fwd_next(input logic [1:0] qs);
    unique case (qs)
      QS_00:   return QS_10;
      QS_10:   return QS_11;
      QS_11:   return QS_01;
      default: return QS_00;
    endcase
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Purpose: per-channel synchroniser plus stable-count glitch filter with discard strobe.
// Latency: SYNC_STAGES + FILTER_CYCLES clocks from pin edge to filt change; bypass loads filt from s directly.
// Backpressure: none, free-running every clock.
module enc_glitch_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int FCNT_W        = $clog2(FILTER_CYCLES + 1)
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic pin,
  input  logic bypass,
  output logic s,
  output logic filt,
  output logic discard
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCNT_W-1:0]      cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // A pending change was abandoned: the synchronised level fell back before the count completed.
  assign discard = !bypass && (s == filt) && (cnt != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (bypass) begin
      filt <= s;
      cnt  <= '0;
    end else if (s != filt) begin
      if (cnt == FCNT_W'(FILTER_CYCLES - 1)) begin
        filt <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + FCNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/enc_quad_frontend.sv
// Purpose: encoder pin conditioning and quadrature decode into step_up/step_down/qerr pulses (ENC_GLITCH_CNT_EN adds glitch counter).
// Latency: SYNC_STAGES+FILTER_CYCLES+1 clocks from pin edge to pulse (7 with defaults).
// Backpressure: none; enable=0 suppresses pulses while filtering and state tracking continue.
module enc_quad_frontend
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enable,
  output logic        a_filt,
  output logic        b_filt,
  output logic [1:0]  quad_state,
  output logic        step_up,
  output logic        step_down,
  output logic        dir,
  output logic        qerr,
`ifdef ENC_GLITCH_CNT_EN
  input  logic        glitch_clr,
  output logic [15:0] glitch_cnt,
`endif
  output logic        primed
);

  localparam int FCNT_W      = $clog2(FILTER_CYCLES + 1);
  localparam int INIT_CYCLES = SYNC_STAGES + FILTER_CYCLES;
  localparam int ICNT_W      = $clog2(INIT_CYCLES);

  logic              s_a, s_b;
  logic              disc_a, disc_b;
  logic [ICNT_W-1:0] icnt;
  logic              prime_done;
  logic [1:0]        new_qs;
  logic              is_fwd, is_rev, is_err;

  enc_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .FCNT_W       (FCNT_W)
  ) u_filt_a (
    .aclk   (aclk),
    .aresetn(aresetn),
    .pin    (enc_a),
    .bypass (!primed),
    .s      (s_a),
    .filt   (a_filt),
    .discard(disc_a)
  );

  enc_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .FCNT_W       (FCNT_W)
  ) u_filt_b (
    .aclk   (aclk),
    .aresetn(aresetn),
    .pin    (enc_b),
    .bypass (!primed),
    .s      (s_b),
    .filt   (b_filt),
    .discard(disc_b)
  );

  assign prime_done = !primed && (icnt == ICNT_W'(INIT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      icnt   <= '0;
      primed <= 1'b0;
    end else if (prime_done) begin
      primed <= 1'b1;
    end else if (!primed) begin
      icnt <= icnt + ICNT_W'(1);
    end
  end

  always_comb begin
    new_qs = {a_filt, b_filt};
    is_fwd = (new_qs == qs_fwd_next(quad_state));
    is_rev = (quad_state == qs_fwd_next(new_qs));
    is_err = (new_qs == ~quad_state);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      quad_state <= QS_00;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      qerr       <= 1'b0;
      dir        <= DIR_UP;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      qerr      <= 1'b0;
      if (prime_done) begin
        // Filters are still in bypass on this edge, so capture the level they are loading.
        quad_state <= {s_a, s_b};
      end else if (primed) begin
        quad_state <= new_qs;
        if (enable) begin
          step_up   <= is_fwd;
          step_down <= is_rev;
          qerr      <= is_err;
          if (is_fwd) begin
            dir <= DIR_UP;
          end else if (is_rev) begin
            dir <= DIR_DOWN;
          end
        end
      end
    end
  end

`ifdef ENC_GLITCH_CNT_EN
  logic [16:0] glitch_sum;

  assign glitch_sum = {1'b0, glitch_cnt} + 17'(disc_a) + 17'(disc_b);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_sum[16]) begin
      glitch_cnt <= 16'hFFFF;
    end else begin
      glitch_cnt <= glitch_sum[15:0];
    end
  end
`else
  logic unused_disc;
  assign unused_disc = disc_a | disc_b;
`endif

endmodule
